rvb_genzip_pipe: RTL and testbench
==================================

// Module: rvb_genzip_pipe
// PURPOSE
//  Parametrised generalised zip/unzip (shfl/unshfl) unit for XLEN=32 or 64 bitmanip datapaths.
//  Permutes a data word by conditionally swapping adjacent index-bit pairs, in shfl or reverse (unshfl) order.
//  Wraps the permutation network in an elastic valid/ready pipeline with configurable register depth.
//  Sits between the operand-read stage and the result mux of the bitmanip execution unit.
// PARAMETERS
//  XLEN      32  data width; legal values 32, 64
//  LOG2X     $clog2(XLEN)  derived, not overridden; mode width
//  PIPE      1   number of register slices (0..2); 0 = combinational pass-through
// PORTS
//  clock      in   1      single clock, all state on rising edge
//  resetn     in   1      asynchronous, active-low reset
//  flush      in   1      synchronous: drops every in-flight operation
//  din_valid  in   1      input operation valid
//  din_ready  out  1      unit can accept input this cycle
//  din_data   in   XLEN   operand
//  din_mode   in   LOG2X  bit0 = 1 unshfl / 0 shfl; bit k (k>=1) enables swap of index bits k,k-1
//  dout_valid out  1      result valid
//  dout_ready in   1      consumer accepts result
//  dout_data  out  XLEN   permuted result
// BEHAVIOUR
//  Permutation: swap(k) maps out[i] = in[i with index bits k and k-1 exchanged].
//   shfl : apply swap(LOG2X-1) down to swap(1), each gated by din_mode[k].
//   unshfl: apply swap(1) up to swap(LOG2X-1), each gated by din_mode[k].
//   unshfl(m, shfl(m, x)) == x for every m; din_mode[LOG2X-1:1]==0 is identity either way.
//  Slicing: network split into PIPE+1 combinational segments; slice j registered after
//   segment j; segments hold ceil((LOG2X-1)/(PIPE+1)) swap levels, last takes remainder.
//   Mode bits travel with data through every slice.
//  Latency: PIPE cycles from accepted input to dout_valid with no back-pressure.
//  Handshake: transfer on valid&&ready at each boundary; per slice
//   ready_in = !slice_valid || ready_out. Full throughput (1 op/cycle) when dout_ready=1.
//   Once dout_valid=1, dout_data stable until dout_ready=1 (no retraction).
//   din_ready is independent of din_valid (no combinational valid->ready path).
//  PIPE=0: dout_valid=din_valid, din_ready=dout_ready, dout_data combinational.
//  Full pipeline + dout_ready=0: din_ready=0; no data overwritten, order preserved.
//  Simultaneous push into a full slice with pop from it in same cycle: both occur.
//  flush: all slice valid bits cleared next edge; input presented that cycle NOT captured;
//   flush has priority over din_valid and dout_ready.
//  Reset (any time, incl. mid-operation): all valid bits 0, all data/mode regs 0;
//   hence dout_valid=0, dout_data=0, din_ready=1 (PIPE>=1) during and after reset.
//  Illegal XLEN or PIPE>2: elaboration-time error.
// STRUCTURE
//  Shared package rvb_pkg: XLEN_32/XLEN_64 constants, MODE_UNSHFL bit index, function
//   idxswap(idx,p,q) exchanging two index bits (reused by other bitmanip permutation units).
//  One sub-module: rvb_zip_seg (params XLEN, FIRST, LAST, DIR-agnostic): applies swap
//   levels FIRST..LAST in shfl or unshfl order selected by mode bit0; combinational.
//  Top instantiates PIPE+1 rvb_zip_seg plus PIPE valid/data/mode register slices.
// TESTING
//  XLEN=32,PIPE=1: din 0xFFFF0000 mode 5'b11110 -> dout 0xAAAAAAAA one cycle later.
//  XLEN=32: din 0xAAAAAAAA mode 5'b11111 -> 0xFFFF0000; din 0x00000002 mode 5'b00010
//   -> 0x00000004; any din with mode 5'b00000 or 5'b00001 -> din unchanged.
//  XLEN=64,PIPE=2: 10k random (x,m) pairs; shfl then unshfl with same m returns x;
//   compare every result against bit-level reference model; latency exactly 2.
//  PIPE=2, dout_ready=0, push ops A,B,C: A,B accepted, din_ready=0 while C held;
//   raise dout_ready -> outputs A,B,C in order, dout_data stable while stalled.
//  Streaming with dout_ready toggling 1,0,1,0: no loss/duplication, throughput 50%.
//  Assert flush with 2 ops in flight -> dout_valid=0 next cycle, neither op appears;
//   drop resetn mid-stream -> dout_valid=0, dout_data=0 immediately, asynchronously.

Source files
------------

// File: rtl/rvb_pkg.sv
// rtl/rvb_pkg.sv - shared constants and index helpers for bitmanip permutation units
package rvb_pkg;

    localparam int XLEN_32     = 32;
    localparam int XLEN_64     = 64;
    localparam int MODE_UNSHFL = 0;

    // Return idx with its bit positions p and q exchanged.
    function automatic int idxswap(input int idx, input int p, input int q);
        int bp;
        int bq;
        int r;
        bp = (idx >> p) & 1;
        bq = (idx >> q) & 1;
        r  = idx & ~((1 << p) | (1 << q));
        r  = r | (bp << q) | (bq << p);
        return r;
    endfunction

endpackage

// File: rtl/rvb_zip_seg.sv
// rtl/rvb_zip_seg.sv - combinational slice of the shfl/unshfl swap network
module rvb_zip_seg
    import rvb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int FIRST = 0,
    parameter int LAST  = 0
) (
    input  logic [XLEN-1:0]         data,
    input  logic [$clog2(XLEN)-1:0] mode,
    output logic [XLEN-1:0]         result
);

    localparam int LOG2X = $clog2(XLEN);
    localparam int NSTEP = LOG2X - 1;

    // FIRST..LAST are positions in the application sequence, not level numbers:
    // shfl visits levels from the top down, unshfl from level 1 up, so the same
    // segment covers mirrored levels depending on direction.
    function automatic logic [XLEN-1:0] swap_level(input logic [XLEN-1:0] x, input int lvl);
        logic [XLEN-1:0] y;
        for (int i = 0; i < XLEN; i++) begin
            y[i] = x[idxswap(i, lvl, lvl - 1)];
        end
        return y;
    endfunction

    logic [XLEN-1:0] shfl_val;
    logic [XLEN-1:0] unshfl_val;

    // Apply this segment's levels in both orders, then select by direction bit.
    always_comb begin
        shfl_val   = data;
        unshfl_val = data;
        for (int p = 0; p < NSTEP; p++) begin
            if (p >= FIRST && p <= LAST && mode[NSTEP - p] == 1'b1) begin
                shfl_val = swap_level(shfl_val, NSTEP - p);
            end
            if (p >= FIRST && p <= LAST && mode[1 + p] == 1'b1) begin
                unshfl_val = swap_level(unshfl_val, 1 + p);
            end
        end
        result = mode[MODE_UNSHFL] ? unshfl_val : shfl_val;
    end

endmodule

// File: rtl/rvb_genzip_pipe.sv
// rtl/rvb_genzip_pipe.sv - elastic pipelined generalised zip/unzip unit
module rvb_genzip_pipe
    import rvb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PIPE = 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [XLEN-1:0]         din_data,
    input  logic [$clog2(XLEN)-1:0] din_mode,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [XLEN-1:0]         dout_data
);

    localparam int LOG2X  = $clog2(XLEN);
    localparam int NSTEP  = LOG2X - 1;
    localparam int SEGLEN = (NSTEP + PIPE) / (PIPE + 1);

    if ((XLEN != XLEN_32 && XLEN != XLEN_64) || PIPE < 0 || PIPE > 2) begin : g_bad_param
        $error("rvb_genzip_pipe: unsupported XLEN or PIPE");
    end

    // Boundary g sits in front of segment g; boundary 0 is the unit input.
    logic [PIPE:0]          vld;
    logic [PIPE:0]          rdy;
    logic [XLEN-1:0]        seg_din  [0:PIPE];
    logic [LOG2X-1:0]       seg_mode [0:PIPE];
    logic [XLEN-1:0]        seg_dout [0:PIPE];

    assign vld[0]      = din_valid;
    assign seg_din[0]  = din_data;
    assign seg_mode[0] = din_mode;

    assign din_ready  = rdy[0];
    assign dout_valid = vld[PIPE];
    assign dout_data  = seg_dout[PIPE];

    // A boundary can accept when its slice is empty or the slice drains this cycle.
    always_comb begin
        rdy       = '0;
        rdy[PIPE] = dout_ready;
        for (int g = PIPE - 1; g >= 0; g--) begin
            rdy[g] = !vld[g + 1] || rdy[g + 1];
        end
    end

    for (genvar g = 0; g <= PIPE; g++) begin : g_stage
        localparam int FIRST_STEP = g * SEGLEN;
        localparam int LAST_STEP  = (g == PIPE) ? NSTEP - 1
                                  : (((g + 1) * SEGLEN < NSTEP) ? (g + 1) * SEGLEN - 1 : NSTEP - 1);

        rvb_zip_seg #(
            .XLEN  (XLEN),
            .FIRST (FIRST_STEP),
            .LAST  (LAST_STEP)
        ) u_seg (
            .data   (seg_din[g]),
            .mode   (seg_mode[g]),
            .result (seg_dout[g])
        );

        if (g < PIPE) begin : g_slice
            logic              valid_q;
            logic [XLEN-1:0]   data_q;
            logic [LOG2X-1:0]  mode_q;

            // Slice register: flush empties it, otherwise load on handshake.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    mode_q  <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else begin
                    if (rdy[g]) begin
                        valid_q <= vld[g];
                    end
                    if (vld[g] && rdy[g]) begin
                        data_q <= seg_dout[g];
                        mode_q <= seg_mode[g];
                    end
                end
            end

            assign vld[g + 1]      = valid_q;
            assign seg_din[g + 1]  = data_q;
            assign seg_mode[g + 1] = mode_q;
        end
    end

endmodule

// File: tb/tb_rvb_genzip_pipe.sv
// tb/tb_rvb_genzip_pipe.sv - self-checking bench for rvb_genzip_pipe
module tb_rvb_genzip_pipe;

    localparam int XLEN = 32;
    localparam int PIPE = 2;
    localparam int L    = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        flush;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic [4:0]  din_mode;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;

    int checks   = 0;
    int failures = 0;
    int pop_count = 0;
    bit rand_done;

    logic [31:0] expq[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    rvb_genzip_pipe #(.XLEN(XLEN), .PIPE(PIPE)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .flush      (flush),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .din_mode   (din_mode),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Model: trace each output bit back to its source index. shfl applies
    // swap(L)..swap(1) to the word, so the source index sees swap(1) first.
    function automatic int sw(input int idx, input int k);
        int b1;
        int b0;
        b1 = (idx >> k) & 1;
        b0 = (idx >> (k - 1)) & 1;
        return (b1 != b0) ? (idx ^ (3 << (k - 1))) : idx;
    endfunction

    function automatic logic [31:0] ref_perm(input logic [31:0] x, input logic [4:0] m);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) begin
            int src;
            src = i;
            if (m[0]) begin
                for (int k = L; k >= 1; k--) if (m[k]) src = sw(src, k);
            end else begin
                for (int k = 1; k <= L; k++) if (m[k]) src = sw(src, k);
            end
            y[i] = x[src];
        end
        return y;
    endfunction

    // Scoreboard: capture accepted inputs, check every output transfer and
    // that a stalled output holds its value.
    always @(negedge clock) begin
        if (!resetn || flush) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", dout_valid, 1);
                check("hold_data", dout_data, prev_data);
            end
            if (dout_valid && dout_ready) begin
                pop_count++;
                if (expq.size() == 0) check("unexpected_dout", dout_valid, 0);
                else check("dout_data", dout_data, expq.pop_front());
            end
            if (din_valid && din_ready) expq.push_back(ref_perm(din_data, din_mode));
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] m);
        int  n;
        logic acc;
        n = 0;
        din_valid = 1'b1;
        din_data  = d;
        din_mode  = m;
        do begin
            @(negedge clock);
            acc = din_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", acc, 1);
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("drain_empty", expq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        resetn = 1'b0; flush = 1'b0; din_valid = 1'b0;
        din_data = '0; din_mode = '0; dout_ready = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout_data", dout_data, 0);
        check("rst_din_ready", din_ready, 1);
        resetn = 1'b1;

        check("model_shfl_all", ref_perm(32'hFFFF0000, 5'b11110), 32'hAAAAAAAA);
        check("model_unshfl_all", ref_perm(32'hAAAAAAAA, 5'b11111), 32'hFFFF0000);
        check("model_swap1", ref_perm(32'h00000002, 5'b00010), 32'h00000004);
        check("model_ident0", ref_perm(32'h12345678, 5'b00000), 32'h12345678);
        check("model_ident1", ref_perm(32'h9ABCDEF0, 5'b00001), 32'h9ABCDEF0);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x;
            logic [4:0]  m;
            x = $urandom;
            m = 5'($urandom) & 5'b11110;
            check("model_roundtrip", ref_perm(ref_perm(x, m), m | 5'b00001), x);
        end

        @(posedge clock); #1;
        send(32'hFFFF0000, 5'b11110);
        @(negedge clock);
        check("lat_cycle1_valid", dout_valid, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("lat_cycle2_valid", dout_valid, 1);
        check("lat_cycle2_data", dout_data, 32'hAAAAAAAA);
        @(posedge clock); #1;

        send(32'hAAAAAAAA, 5'b11111);
        send(32'h00000002, 5'b00010);
        send(32'h12345678, 5'b00000);
        send(32'h9ABCDEF0, 5'b00001);
        send(32'h0F0F00FF, 5'b10101);
        drain();

        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(3) == 0) begin @(posedge clock); #1; end
                    send($urandom, 5'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    dout_ready = 1'($urandom_range(1));
                    @(posedge clock); #1;
                end
            end
        join
        dout_ready = 1'b1;
        drain();

        dout_ready = 1'b0;
        send(32'h11111111, 5'b00110);
        send(32'h22222222, 5'b11000);
        din_valid = 1'b1; din_data = 32'h33333333; din_mode = 5'b01011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_din_ready", din_ready, 0);
            check("stall_head_data", dout_data, ref_perm(32'h11111111, 5'b00110));
            @(posedge clock); #1;
        end
        dout_ready = 1'b1;
        send(32'h33333333, 5'b01011);
        drain();

        fork
            begin
                for (int i = 0; i < 24; i++) send(32'h5A5A5A5A ^ (i * 32'h01010101), 5'(i));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    dout_ready = (c % 2 == 0);
                    @(posedge clock); #1;
                end
                dout_ready = 1'b1;
            end
            begin
                repeat (6) @(posedge clock);
                #1;
                n0 = pop_count;
                repeat (20) @(posedge clock);
                #1;
                check("throughput_half", pop_count - n0, 10);
            end
        join
        dout_ready = 1'b1;
        drain();

        dout_ready = 1'b0;
        send(32'hCAFEF00D, 5'b11110);
        send(32'h0BADBEEF, 5'b00011);
        flush = 1'b1; din_valid = 1'b1; din_data = 32'h44444444; dout_ready = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("flush_dout_valid", dout_valid, 0);
            @(posedge clock); #1;
        end

        din_valid = 1'b1; din_mode = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            din_data = 32'hDEAD0001 + i;
            @(posedge clock); #1;
        end
        check("pre_reset_valid", dout_valid, 1);
        #1;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", dout_valid, 0);
        check("async_rst_data", dout_data, 0);
        check("async_rst_ready", din_ready, 1);
        din_valid = 1'b0;
        @(posedge clock); @(posedge clock); #3;
        resetn = 1'b1;
        @(posedge clock); #1;
        send(32'h80000001, 5'b11111);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
